irq_controller12: RTL and testbench

- Interrupt controller directly upstream of the 12-bit processor core.
- Latches rising edges on 24 external interrupt lines into a pending register and applies a software-writable mask.
- Presents the highest-priority unmasked interrupt to the core as a request/vector pair, using an ack / end-of-interrupt handshake.
- Its mask and pending registers are accessed over the core's 12-bit data bus.

---
 rtl/irq_controller12_pkg.sv | 20 ++
 rtl/irq_edge_sync.sv | 30 +++
 rtl/irq_controller12.sv | 127 ++++++++++++
 tb/tb_irq_controller12.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_controller12_pkg.sv
// Shared constants and types for the 24-line interrupt controller.
// Register addresses, FSM state encoding and bus/vector widths.
package irq_controller12_pkg;

  localparam int unsigned NUM_IRQ = 24;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned VEC_W   = 5;

  localparam logic [1:0] ADDR_MASK_LO = 2'd0;
  localparam logic [1:0] ADDR_MASK_HI = 2'd1;
  localparam logic [1:0] ADDR_PEND_LO = 2'd2;
  localparam logic [1:0] ADDR_PEND_HI = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_edge_sync.sv
// Two-flop synchroniser plus rising-edge detect, one lane per input bit.
// All flops clear on reset so a line already high at release yields one edge.
module irq_edge_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] sync1_q;
  logic [W-1:0] sync2_q;
  logic [W-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/irq_controller12.sv
// Interrupt controller: edge-latched pending bits, software mask, fixed
// lowest-index priority and a req/ack/eoi handshake towards the core.
module irq_controller12
  import irq_controller12_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               reg_we,
  input  logic               reg_re,
  input  logic [1:0]         reg_addr,
  input  logic [DATA_W-1:0]  reg_wdata,
  output logic [DATA_W-1:0]  reg_rdata,
  output logic               int_req,
  output logic [VEC_W-1:0]   int_vector,
  input  logic               int_ack,
  input  logic               int_eoi
);

  function automatic logic [VEC_W-1:0] lowest_index(input logic [NUM_IRQ-1:0] v);
    logic [VEC_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (v[i] && !found) begin
        idx   = VEC_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] pending_d;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] clr_w1c;
  logic [NUM_IRQ-1:0] clr_ack;
  logic [DATA_W-1:0]  rdata_q;
  logic [VEC_W-1:0]   vec_q;
  logic [VEC_W-1:0]   vec_d;
  logic               ack_fire;
  irq_state_t         state_q;
  irq_state_t         state_d;

  irq_edge_sync #(.W(NUM_IRQ)) u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (irq_in),
    .rise (irq_rise)
  );

  assign active = pending_q & ~mask_q;

  always_comb begin
    clr_w1c = '0;
    if (reg_we && reg_addr == ADDR_PEND_LO) clr_w1c[DATA_W-1:0]       = reg_wdata;
    if (reg_we && reg_addr == ADDR_PEND_HI) clr_w1c[NUM_IRQ-1:DATA_W] = reg_wdata;
  end

  assign clr_ack = ack_fire ? (NUM_IRQ'(1) << vec_q) : '0;

  // A fresh edge outranks any clear landing on the same bit in the same cycle.
  assign pending_d = (pending_q & ~(clr_w1c | clr_ack)) | irq_rise;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q <= '0;
      mask_q    <= '1;
      rdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      if (reg_we && reg_addr == ADDR_MASK_LO) mask_q[DATA_W-1:0]       <= reg_wdata;
      if (reg_we && reg_addr == ADDR_MASK_HI) mask_q[NUM_IRQ-1:DATA_W] <= reg_wdata;
      if (reg_re) begin
        case (reg_addr)
          ADDR_MASK_LO: rdata_q <= mask_q[DATA_W-1:0];
          ADDR_MASK_HI: rdata_q <= mask_q[NUM_IRQ-1:DATA_W];
          ADDR_PEND_LO: rdata_q <= pending_q[DATA_W-1:0];
          default:      rdata_q <= pending_q[NUM_IRQ-1:DATA_W];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  // The vector is only re-latched in IDLE, so it stays frozen through REQ.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    ack_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (|active) begin
          vec_d   = lowest_index(active);
          state_d = REQ;
        end
      end
      REQ: begin
        if (int_ack) begin
          ack_fire = 1'b1;
          state_d  = SERVICE;
        end
      end
      SERVICE: begin
        if (int_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign int_req    = (state_q == REQ);
  assign int_vector = vec_q;
  assign reg_rdata  = rdata_q;

endmodule

// File: tb/tb_irq_controller12.sv
// Bench for irq_controller12: table-driven main sequence plus hand-written
// handshake corner cases; register reads are checked through a scoreboard.
module tb_irq_controller12;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] irq_in;
  logic        reg_we;
  logic        reg_re;
  logic [1:0]  reg_addr;
  logic [11:0] reg_wdata;
  logic [11:0] reg_rdata;
  logic        int_req;
  logic [4:0]  int_vector;
  logic        int_ack;
  logic        int_eoi;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] sb_q[$];

  irq_controller12 dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .int_req    (int_req),
    .int_vector (int_vector),
    .int_ack    (int_ack),
    .int_eoi    (int_eoi)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic        re;
    logic [1:0]  addr;
    logic [11:0] wdata;
    logic [23:0] irq;
    logic        ack;
    logic        eoi;
    logic        exp_req;
    logic [4:0]  exp_vec;
    logic [11:0] exp_rdata;
  } row_t;

  row_t tbl[28];

  function automatic row_t mk(logic we, logic re, logic [1:0] addr, logic [11:0] wdata,
                              logic [23:0] irq, logic ack, logic eoi,
                              logic exp_req, logic [4:0] exp_vec, logic [11:0] exp_rdata);
    row_t r;
    r.we = we; r.re = re; r.addr = addr; r.wdata = wdata; r.irq = irq;
    r.ack = ack; r.eoi = eoi; r.exp_req = exp_req; r.exp_vec = exp_vec;
    r.exp_rdata = exp_rdata;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    irq_in = '0; reg_we = 0; reg_re = 0; reg_addr = '0; reg_wdata = '0;
    int_ack = 0; int_eoi = 0;
  endtask

  task automatic chk(string name, logic [11:0] act, logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%03h required=0x%03h", name, act, exp);
    end
  endtask

  task automatic chk_req(string name, logic exp_req, logic [4:0] exp_vec);
    chk({name, "_req"}, {11'd0, int_req}, {11'd0, exp_req});
    if (exp_req) chk({name, "_vec"}, {7'd0, int_vector}, {7'd0, exp_vec});
  endtask

  task automatic pop_rd(string name);
    logic [11:0] e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: actual=empty scoreboard required=entry", name);
    end else begin
      e = sb_q.pop_front();
      chk(name, reg_rdata, e);
    end
  endtask

  task automatic wr(logic [1:0] addr, logic [11:0] data);
    reg_we = 1; reg_addr = addr; reg_wdata = data;
    step();
    reg_we = 0;
  endtask

  task automatic rd(string name, logic [1:0] addr, logic [11:0] exp);
    reg_re = 1; reg_addr = addr;
    sb_q.push_back(exp);
    step();
    reg_re = 0;
    pop_rd(name);
  endtask

  initial begin
    tbl[0]  = mk(0,1,2'd0,12'h000,24'h0,0,0, 0,5'd0, 12'hFFF);
    tbl[1]  = mk(0,1,2'd1,12'h000,24'h0,0,0, 0,5'd0, 12'hFFF);
    tbl[2]  = mk(0,1,2'd2,12'h000,24'h0,0,0, 0,5'd0, 12'h000);
    tbl[3]  = mk(0,1,2'd3,12'h000,24'h0,0,0, 0,5'd0, 12'h000);
    tbl[4]  = mk(1,0,2'd0,12'hFF7,24'h0,0,0, 0,5'd0, 12'h000);
    tbl[5]  = mk(0,0,2'd0,12'h000,24'h000008,0,0, 0,5'd0, 12'h000);
    tbl[6]  = mk(0,0,2'd0,12'h000,24'h0,0,0, 0,5'd0, 12'h000);
    tbl[7]  = mk(0,0,2'd0,12'h000,24'h0,0,0, 0,5'd0, 12'h000);
    tbl[8]  = mk(0,0,2'd0,12'h000,24'h0,0,0, 1,5'd3, 12'h000);
    tbl[9]  = mk(0,1,2'd2,12'h000,24'h0,0,0, 1,5'd3, 12'h008);
    tbl[10] = mk(0,0,2'd0,12'h000,24'h0,1,0, 0,5'd0, 12'h000);
    tbl[11] = mk(0,1,2'd2,12'h000,24'h0,0,0, 0,5'd0, 12'h000);
    tbl[12] = mk(0,0,2'd0,12'h000,24'h0,0,1, 0,5'd0, 12'h000);
    tbl[13] = mk(0,0,2'd0,12'h000,24'h0,0,0, 0,5'd0, 12'h000);
    tbl[14] = mk(1,0,2'd0,12'h000,24'h0,0,0, 0,5'd0, 12'h000);
    tbl[15] = mk(1,0,2'd1,12'h000,24'h0,0,0, 0,5'd0, 12'h000);
    tbl[16] = mk(0,0,2'd0,12'h000,24'h100020,0,0, 0,5'd0, 12'h000);
    tbl[17] = mk(0,0,2'd0,12'h000,24'h0,0,0, 0,5'd0, 12'h000);
    tbl[18] = mk(0,0,2'd0,12'h000,24'h0,0,0, 0,5'd0, 12'h000);
    tbl[19] = mk(0,0,2'd0,12'h000,24'h0,0,0, 1,5'd5, 12'h000);
    tbl[20] = mk(0,1,2'd3,12'h000,24'h0,0,0, 1,5'd5, 12'h100);
    tbl[21] = mk(0,0,2'd0,12'h000,24'h0,1,0, 0,5'd0, 12'h000);
    tbl[22] = mk(0,0,2'd0,12'h000,24'h0,0,1, 0,5'd0, 12'h000);
    tbl[23] = mk(0,0,2'd0,12'h000,24'h0,0,0, 1,5'd20,12'h000);
    tbl[24] = mk(0,1,2'd3,12'h000,24'h0,0,0, 1,5'd20,12'h100);
    tbl[25] = mk(0,0,2'd0,12'h000,24'h0,1,0, 0,5'd0, 12'h000);
    tbl[26] = mk(0,0,2'd0,12'h000,24'h0,0,1, 0,5'd0, 12'h000);
    tbl[27] = mk(0,0,2'd0,12'h000,24'h0,0,0, 0,5'd0, 12'h000);

    idle_inputs();
    rst = 0;
    step(); step(); step();
    chk("reset_req",   {11'd0, int_req}, 12'h000);
    chk("reset_vec",   {7'd0, int_vector}, 12'h000);
    chk("reset_rdata", reg_rdata, 12'h000);
    rst = 1;

    for (int i = 0; i < 28; i++) begin
      reg_we = tbl[i].we; reg_re = tbl[i].re; reg_addr = tbl[i].addr;
      reg_wdata = tbl[i].wdata; irq_in = tbl[i].irq;
      int_ack = tbl[i].ack; int_eoi = tbl[i].eoi;
      if (tbl[i].re) sb_q.push_back(tbl[i].exp_rdata);
      step();
      chk_req($sformatf("row%0d", i), tbl[i].exp_req, tbl[i].exp_vec);
      if (tbl[i].re) pop_rd($sformatf("row%0d_rdata", i));
    end
    idle_inputs();

    // Masked line 7 stays pending without a request until unmasked.
    wr(2'd0, 12'hFFF);
    irq_in = 24'h000080; step(); irq_in = '0;
    step(); step(); step(); step();
    chk_req("masked_no_req", 0, 5'd0);
    rd("masked_pend_lo", 2'd2, 12'h080);
    wr(2'd0, 12'hF7F);
    chk_req("unmask_same_edge", 0, 5'd0);
    step();
    chk_req("unmask_req7", 1, 5'd7);
    int_ack = 1; step(); int_ack = 0;
    chk_req("ack7_drop", 0, 5'd0);
    int_eoi = 1; step(); int_eoi = 0;
    step();
    chk_req("after_eoi7", 0, 5'd0);

    // New edge on line 2 arrives in the same cycle as its ack.
    wr(2'd0, 12'hFFB);
    irq_in = 24'h000004; step(); irq_in = '0;
    step(); step(); step();
    chk_req("req2", 1, 5'd2);
    irq_in = 24'h000004; step(); irq_in = '0;
    step();
    int_ack = 1; step(); int_ack = 0;
    chk_req("ack2_drop", 0, 5'd0);
    rd("set_wins_pend", 2'd2, 12'h004);
    chk_req("service_no_req", 0, 5'd0);
    int_eoi = 1; step(); int_eoi = 0;
    chk_req("eoi2_idle", 0, 5'd0);
    step();
    chk_req("rereq2", 1, 5'd2);
    int_ack = 1; step(); int_ack = 0;

    // Reset while in SERVICE with a masked line pending.
    irq_in = 24'h000200; step(); irq_in = '0;
    step(); step();
    rd("pre_reset_pend", 2'd2, 12'h200);
    rst = 0; step(); rst = 1;
    chk_req("svc_reset_req", 0, 5'd0);
    chk("svc_reset_rdata", reg_rdata, 12'h000);
    rd("svc_reset_mask_lo", 2'd0, 12'hFFF);
    rd("svc_reset_mask_hi", 2'd1, 12'hFFF);
    rd("svc_reset_pend_lo", 2'd2, 12'h000);
    rd("svc_reset_pend_hi", 2'd3, 12'h000);
    int_eoi = 1; step(); int_eoi = 0;
    step();
    chk_req("eoi_after_reset", 0, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
